// File: rtl/incdec_step_arbiter.sv
// ---------------------------------------------------------------------------
// IncDecStepArbiter: incdec_step_arbiter
//
// Sequences one shared increment/decrement datapath between two requesters.
// A granted requester's start value is stepped by +1 or -1 once per clock for
// N clocks. The final value is then returned with a flag that says whether any
// step overflowed.
//
// Ports:
//   clk                  rising-edge system clock
//   rst_n                asynchronous active-low reset
//   req0/op0/a0/n0       requester 0: request, direction (0=inc, 1=dec),
//                        start value, step count
//   req1/op1/a1/n1       requester 1, same meaning
//   gnt0/gnt1            one-cycle grant pulses (operands latched)
//   done0/done1          one-cycle completion pulses
//   result               final value, valid with doneX, held until next done
//   wrap                 carry/borrow (or saturation) seen on some step
//   busy                 high whenever the sequencer is not idle
//
// Build option:
//   SATURATE_EN          when defined, steps saturate at 0 / 2^WIDTH-1 and
//                        wrap reports that saturation was hit; otherwise
//                        arithmetic is modulo 2^WIDTH.
// ---------------------------------------------------------------------------
module incdec_step_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [CNT_W-1:0] n0,
    input  logic             req1,
    input  logic             op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [CNT_W-1:0] n1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             wrap,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] rem_q;
    logic             op_q;
    logic             owner_q;
    logic             prio_q;
    logic             wrapAcc_q;

    logic [WIDTH-1:0] acc_d;
    logic             stepHit;
    logic             pick0;
    logic             pick1;
    logic             selOp;
    logic [WIDTH-1:0] selA;
    logic [CNT_W-1:0] selN;

    // One datapath step on the accumulator. stepHit flags the boundary case:
    // carry/borrow out in modulo mode, or an attempt to pass a limit when
    // saturating.
    always_comb begin
        acc_d   = acc_q;
        stepHit = 1'b0;
`ifdef SATURATE_EN
        if (!op_q) begin
            if (acc_q == {WIDTH{1'b1}}) begin
                stepHit = 1'b1;
            end else begin
                acc_d = acc_q + WIDTH'(1);
            end
        end else begin
            if (acc_q == '0) begin
                stepHit = 1'b1;
            end else begin
                acc_d = acc_q - WIDTH'(1);
            end
        end
`else
        if (!op_q) begin
            {stepHit, acc_d} = {1'b0, acc_q} + (WIDTH+1)'(1);
        end else begin
            {stepHit, acc_d} = {1'b0, acc_q} - (WIDTH+1)'(1);
        end
`endif
    end

    // Round-robin pick: prio_q == 0 lets requester 0 win a tie, prio_q == 1
    // lets requester 1 win. A lone requester always wins.
    always_comb begin
        pick0 = req0 && (!req1 || !prio_q);
        pick1 = req1 && (!req0 ||  prio_q);
        selOp = pick1 ? op1 : op0;
        selA  = pick1 ? a1  : a0;
        selN  = pick1 ? n1  : n0;
    end

    // Sequencer FSM. All outputs are registered here. Pulses default low each
    // cycle. done is raised on the edge that enters DONE, so it lines up with
    // the DONE state. With a zero step count that edge is the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            rem_q     <= '0;
            op_q      <= 1'b0;
            owner_q   <= 1'b0;
            prio_q    <= 1'b0;
            wrapAcc_q <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            result    <= '0;
            wrap      <= 1'b0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick0 || pick1) begin
                        gnt0      <= pick0;
                        gnt1      <= pick1;
                        owner_q   <= pick1;
                        prio_q    <= pick0;
                        op_q      <= selOp;
                        acc_q     <= selA;
                        rem_q     <= selN;
                        wrapAcc_q <= 1'b0;
                        wrap      <= 1'b0;
                        if (selN == '0) begin
                            state_q <= DONE;
                            done0   <= pick0;
                            done1   <= pick1;
                            result  <= selA;
                        end else begin
                            state_q <= STEP;
                        end
                    end
                end
                STEP: begin
                    acc_q     <= acc_d;
                    rem_q     <= rem_q - CNT_W'(1);
                    wrapAcc_q <= wrapAcc_q | stepHit;
                    if (rem_q == CNT_W'(1)) begin
                        state_q <= DONE;
                        done0   <= !owner_q;
                        done1   <= owner_q;
                        result  <= acc_d;
                        wrap    <= wrapAcc_q | stepHit;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_incdec_step_arbiter.sv
// ---------------------------------------------------------------------------
// TbIncDecStepArbiter: tb_incdec_step_arbiter
//
// Directed testbench for incdec_step_arbiter. It drives hand-built request
// sequences. Every observation is compared against a constant that was
// worked out by hand from the block's behaviour.
// ---------------------------------------------------------------------------
module tb_incdec_step_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, op0, req1, op1;
    logic [3:0] a0, n0, a1, n1;
    logic       gnt0, gnt1, done0, done1, wrap, busy;
    logic [3:0] result;

    int checks = 0;
    int errors = 0;
    logic sawDone;

`ifdef SATURATE_EN
    localparam logic [3:0] DEC_RESULT  = 4'd0;
    localparam logic [3:0] INC15_RESULT = 4'd15;
`else
    localparam logic [3:0] DEC_RESULT  = 4'd14;
    localparam logic [3:0] INC15_RESULT = 4'd14;
`endif

    incdec_step_arbiter #(.WIDTH(4), .CNT_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .op0    (op0),
        .a0     (a0),
        .n0     (n0),
        .req1   (req1),
        .op1    (op1),
        .a1     (a1),
        .n1     (n1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .result (result),
        .wrap   (wrap),
        .busy   (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observation against its expected value and log failures.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence.
    initial begin
        rst_n = 1'b0;
        req0 = 0; op0 = 0; a0 = 0; n0 = 0;
        req1 = 0; op1 = 0; a1 = 0; n1 = 0;
        #2;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_gnt", {gnt1, gnt0}, 0);
        checkOutput("rst_done", {done1, done0}, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_wrap", wrap, 0);
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();

        // Requester 0 increments 3 by 4 steps.
        req0 = 1; op0 = 0; a0 = 4'd3; n0 = 4'd4;
        applyStimulus();
        checkOutput("t1_gnt0", gnt0, 1);
        checkOutput("t1_gnt1", gnt1, 0);
        checkOutput("t1_busy", busy, 1);
        req0 = 0; a0 = 4'd0; n0 = 4'd1;
        repeat (3) applyStimulus();
        checkOutput("t1_noEarlyDone", done0, 0);
        applyStimulus();
        checkOutput("t1_done0", done0, 1);
        checkOutput("t1_result", result, 4'd7);
        checkOutput("t1_wrap", wrap, 0);
        applyStimulus();
        checkOutput("t1_doneDrop", done0, 0);
        checkOutput("t1_idle", busy, 0);
        checkOutput("t1_resultHeld", result, 4'd7);

        // Requester 1 decrements 1 by 3 steps, crossing zero.
        req1 = 1; op1 = 1; a1 = 4'd1; n1 = 4'd3;
        applyStimulus();
        checkOutput("t2_gnt1", gnt1, 1);
        checkOutput("t2_gnt0", gnt0, 0);
        req1 = 0;
        repeat (3) applyStimulus();
        checkOutput("t2_done1", done1, 1);
        checkOutput("t2_done0", done0, 0);
        checkOutput("t2_result", result, DEC_RESULT);
        checkOutput("t2_wrap", wrap, 1);
        applyStimulus();

        // Zero step count: grant and done coincide, value passes through.
        req0 = 1; op0 = 0; a0 = 4'd9; n0 = 4'd0;
        applyStimulus();
        checkOutput("t3_gnt0", gnt0, 1);
        checkOutput("t3_done0", done0, 1);
        checkOutput("t3_result", result, 4'd9);
        checkOutput("t3_wrap", wrap, 0);
        req0 = 0;
        applyStimulus();
        checkOutput("t3_pulses", {gnt0, done0}, 0);
        checkOutput("t3_idle", busy, 0);

        // Tie from reset: requester 0 first, then alternation.
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();
        req0 = 1; op0 = 0; a0 = 4'd2; n0 = 4'd1;
        req1 = 1; op1 = 1; a1 = 4'd5; n1 = 4'd1;
        applyStimulus();
        checkOutput("t4_first", {gnt1, gnt0}, 2'b01);
        req0 = 0;
        applyStimulus();
        checkOutput("t4_done0", done0, 1);
        checkOutput("t4_result0", result, 4'd3);
        req0 = 1;
        applyStimulus();
        checkOutput("t4_ignoredInDone", {gnt1, gnt0}, 0);
        applyStimulus();
        checkOutput("t4_second", {gnt1, gnt0}, 2'b10);
        req1 = 0;
        applyStimulus();
        checkOutput("t4_done1", {done1, done0}, 2'b10);
        checkOutput("t4_result1", result, 4'd4);
        req1 = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("t4_third", {gnt1, gnt0}, 2'b01);
        req0 = 0; req1 = 0;
        applyStimulus();
        checkOutput("t4_done0b", done0, 1);
        applyStimulus();
        checkOutput("t4_idle", busy, 0);

        // Long increment with wrap; requester 1 arrives mid-operation.
        req0 = 1; op0 = 0; a0 = 4'd15; n0 = 4'd15;
        applyStimulus();
        checkOutput("t5_gnt0", gnt0, 1);
        req0 = 0; a0 = 4'd0; op0 = 1;
        applyStimulus();
        req1 = 1; op1 = 0; a1 = 4'd1; n1 = 4'd1;
        repeat (13) applyStimulus();
        checkOutput("t5_req1Ignored", gnt1, 0);
        checkOutput("t5_busy", busy, 1);
        checkOutput("t5_noEarlyDone", done0, 0);
        applyStimulus();
        checkOutput("t5_done0", done0, 1);
        checkOutput("t5_result", result, INC15_RESULT);
        checkOutput("t5_wrap", wrap, 1);
        applyStimulus();
        checkOutput("t5_stillNoGnt1", gnt1, 0);
        checkOutput("t5_idle", busy, 0);
        applyStimulus();
        checkOutput("t5_gnt1", gnt1, 1);
        req1 = 0;
        applyStimulus();
        checkOutput("t5_done1", done1, 1);
        checkOutput("t5_result1", result, 4'd2);
        applyStimulus();

        // Reset in the middle of STEP aborts the operation.
        req0 = 1; op0 = 0; a0 = 4'd0; n0 = 4'd10;
        applyStimulus();
        req0 = 0;
        repeat (3) applyStimulus();
        checkOutput("t6_busyBefore", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_result", result, 0);
        checkOutput("t6_wrap", wrap, 0);
        checkOutput("t6_pulses", {gnt1, gnt0, done1, done0}, 0);
        applyStimulus();
        rst_n = 1'b1;
        sawDone = 1'b0;
        for (int i = 0; i < 14; i++) begin
            applyStimulus();
            sawDone = sawDone | done0 | done1;
        end
        checkOutput("t6_noDoneAfter", sawDone, 0);
        checkOutput("t6_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
